// File: rtl/stack_up_rx.sv
// Upstream receive stage: framing checker, receive FIFO with registered ready,
// and a saturating packet counter with a sticky framing-error flag.
module stack_up_rx #(
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              mgr__stu__valid,
  input  logic [1:0]        mgr__stu__cntl,
  output logic              stu__mgr__ready,
  input  logic [TYPE_W-1:0] mgr__stu__type,
  input  logic [DATA_W-1:0] mgr__stu__data,
  input  logic [OOB_W-1:0]  mgr__stu__oob_data,
  output logic              stu__cons__valid,
  output logic [1:0]        stu__cons__cntl,
  output logic [TYPE_W-1:0] stu__cons__type,
  output logic [DATA_W-1:0] stu__cons__data,
  output logic [OOB_W-1:0]  stu__cons__oob_data,
  input  logic              cons__stu__ready,
  input  logic              sys__stu__clear,
  output logic [15:0]       stu__sys__pktCount,
  output logic              stu__sys__protoErr
);

  localparam int AW       = $clog2(DEPTH);
  localparam int ENT_W    = 2 + TYPE_W + DATA_W + OOB_W;
  localparam int DATA_LSB = OOB_W;
  localparam int TYPE_LSB = OOB_W + DATA_W;
  localparam int CNTL_LSB = OOB_W + DATA_W + TYPE_W;
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("stack_up_rx: DEPTH must be a power of 2 and at least 4");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_d;
  logic             ready_q, ready_d;
  logic [0:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             in_xfer, wr_en, rd_en, empty, full;
  logic             pkt_done, frame_err;
  logic [ENT_W-1:0] head, head_vis;

  assign in_xfer = mgr__stu__valid & ready_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = ~empty & cons__stu__ready;

  // Framing: only accepted beats advance the FSM; stray MOM/EOM in IDLE are dropped
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    pkt_done  = 1'b0;
    frame_err = 1'b0;
    if (in_xfer) begin
      if (state_q == ST_IDLE) begin
        case (mgr__stu__cntl)
          CNTL_SOM: begin
            wr_en   = 1'b1;
            state_d = ST_IN_PKT;
          end
          CNTL_SOM_EOM: begin
            wr_en    = 1'b1;
            pkt_done = 1'b1;
          end
          default: frame_err = 1'b1;
        endcase
      end else begin
        wr_en = 1'b1;
        case (mgr__stu__cntl)
          CNTL_MOM: state_d = ST_IN_PKT;
          CNTL_EOM: begin
            pkt_done = 1'b1;
            state_d  = ST_IDLE;
          end
          CNTL_SOM: begin
            frame_err = 1'b1;
            state_d   = ST_IN_PKT;
          end
          default: begin
            frame_err = 1'b1;
            pkt_done  = 1'b1;
            state_d   = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Ready looks at next-cycle occupancy so one in-flight beat always has room
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    occ_d    = wr_ptr_d - rd_ptr_d;
    ready_d  = (occ_d <= READY_MAX);
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (sys__stu__clear) begin
      cnt_d = 16'd0;
      err_d = 1'b0;
    end else begin
      if (pkt_done) cnt_d = sat_inc(cnt_q);
      if (frame_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; the output is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {mgr__stu__cntl, mgr__stu__type,
                                  mgr__stu__data, mgr__stu__oob_data};
    end
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_vis = empty ? '0 : head;

  assign stu__mgr__ready     = ready_q;
  assign stu__cons__valid    = ~empty;
  assign stu__cons__cntl     = head_vis[CNTL_LSB +: 2];
  assign stu__cons__type     = head_vis[TYPE_LSB +: TYPE_W];
  assign stu__cons__data     = head_vis[DATA_LSB +: DATA_W];
  assign stu__cons__oob_data = head_vis[0 +: OOB_W];
  assign stu__sys__pktCount  = cnt_q;
  assign stu__sys__protoErr  = err_q;

  wr_full_a: assert property (@(posedge clk) disable iff (reset_poweron) !(wr_en && full));

endmodule

// File: tb/tb_stack_up_rx.sv
// Bench for stack_up_rx: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_stack_up_rx;
  localparam int DATA_W = 64;
  localparam int OOB_W  = 32;
  localparam int TYPE_W = 2;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_poweron;
  logic              mvalid;
  logic [1:0]        mcntl;
  logic              sready;
  logic [TYPE_W-1:0] mtype;
  logic [DATA_W-1:0] mdata;
  logic [OOB_W-1:0]  moob;
  logic              cvalid;
  logic [1:0]        ccntl;
  logic [TYPE_W-1:0] ctype;
  logic [DATA_W-1:0] cdata;
  logic [OOB_W-1:0]  coob;
  logic              cready;
  logic              clear;
  logic [15:0]       pkt;
  logic              perr;

  stack_up_rx #(.DATA_W(DATA_W), .OOB_W(OOB_W), .TYPE_W(TYPE_W), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .mgr__stu__valid     (mvalid),
    .mgr__stu__cntl      (mcntl),
    .stu__mgr__ready     (sready),
    .mgr__stu__type      (mtype),
    .mgr__stu__data      (mdata),
    .mgr__stu__oob_data  (moob),
    .stu__cons__valid    (cvalid),
    .stu__cons__cntl     (ccntl),
    .stu__cons__type     (ctype),
    .stu__cons__data     (cdata),
    .stu__cons__oob_data (coob),
    .cons__stu__ready    (cready),
    .sys__stu__clear     (clear),
    .stu__sys__pktCount  (pkt),
    .stu__sys__protoErr  (perr)
  );

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } beat_t;

  beat_t             mq[$];
  bit                m_in_pkt;
  bit                m_ready;
  logic [15:0]       m_cnt;
  bit                m_err;
  bit                chk_en = 1'b0;
  logic [DATA_W-1:0] outlog[$];
  int                total = 0;
  int                bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored beats plus packet/error bookkeeping
  always @(posedge clk) begin : model
    bit    done;
    bit    err;
    beat_t b;
    done = 1'b0;
    err  = 1'b0;
    if (reset_poweron) begin
      mq.delete();
      m_in_pkt = 1'b0;
      m_ready  = 1'b0;
      m_cnt    = 16'd0;
      m_err    = 1'b0;
      chk_en   = 1'b1;
    end else begin
      if (cready && mq.size() > 0) void'(mq.pop_front());
      if (mvalid && m_ready) begin
        if (!m_in_pkt && (mcntl == 2'b00 || mcntl == 2'b10)) begin
          err = 1'b1;
        end else begin
          b = {mcntl, mtype, mdata, moob};
          mq.push_back(b);
          if (m_in_pkt && mcntl[0]) err = 1'b1;
          done     = (mcntl == 2'b11) || (m_in_pkt && mcntl == 2'b10);
          m_in_pkt = (mcntl == 2'b01) || (m_in_pkt && mcntl == 2'b00);
        end
      end
      if (clear) begin
        m_cnt = 16'd0;
        m_err = 1'b0;
      end else begin
        if (done && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (err) m_err = 1'b1;
      end
      m_ready = (mq.size() <= DEPTH - 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", sready, m_ready);
      check("valid", cvalid, mq.size() > 0);
      check("pktCount", pkt, m_cnt);
      check("protoErr", perr, m_err);
      if (mq.size() > 0) begin
        check("head_cntl", ccntl, mq[0].cntl);
        check("head_type", ctype, mq[0].typ);
        check("head_data", cdata, mq[0].data);
        check("head_oob", coob, mq[0].oob);
      end else begin
        check("idle_outputs", {ccntl, ctype, coob}, 0);
        check("idle_data", cdata, 0);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!reset_poweron && cvalid && cready) outlog.push_back(cdata);
  end

  // Called at a negedge; holds the beat until accepted, returns at the following negedge
  task automatic send(input logic [1:0] c, input logic [DATA_W-1:0] d);
    int n;
    n      = 0;
    mvalid = 1'b1;
    mcntl  = c;
    mdata  = d;
    mtype  = TYPE_W'($urandom);
    moob   = $urandom;
    while (!sready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: waited %0d cycles, limit 200", n);
    end
    @(negedge clk);
    mvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    reset_poweron = 1'b1;
    mvalid = 1'b0; mcntl = 2'b00; mtype = '0; mdata = '0; moob = '0;
    cready = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", sready, 0);
    check("rst_valid", cvalid, 0);
    check("rst_cnt", pkt, 0);
    check("rst_err", perr, 0);
    check("rst_data", cdata, 0);
    reset_poweron = 1'b0;
    @(negedge clk);
    check("ready_after_rst", sready, 1);

    // Single SOM_EOM beat
    cready = 1'b1;
    send(2'b11, 64'h1234);
    check("single_valid", cvalid, 1);
    check("single_data", cdata, 64'h1234);
    check("single_cntl", ccntl, 2'b11);
    check("single_cnt", pkt, 1);
    check("single_err", perr, 0);

    // Backpressure: ten beats against a stalled consumer
    @(negedge clk);
    cready = 1'b0;
    outlog.delete();
    pulse_clear();
    fork
      begin
        for (int i = 0; i < 10; i++)
          send((i == 0) ? 2'b01 : ((i == 9) ? 2'b10 : 2'b00), DATA_W'(i));
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_ready_at_6", sready, 1);
        @(negedge clk);
        check("bp_ready_at_7", sready, 0);
        repeat (2) @(negedge clk);
        check("bp_still_low", sready, 0);
        cready = 1'b1;
      end
    join
    repeat (15) @(negedge clk);
    check("bp_count", outlog.size(), 10);
    for (int i = 0; i < 10 && i < outlog.size(); i++) check("bp_order", outlog[i], i);
    check("bp_pkt", pkt, 1);
    check("bp_err", perr, 0);

    // Framing error then a clean packet
    pulse_clear();
    outlog.delete();
    send(2'b00, 64'hAA);
    check("ferr_flag", perr, 1);
    send(2'b01, 64'h1);
    send(2'b00, 64'h2);
    send(2'b10, 64'h3);
    repeat (4) @(negedge clk);
    check("ferr_beats", outlog.size(), 3);
    for (int i = 0; i < 3 && i < outlog.size(); i++) check("ferr_data", outlog[i], i + 1);
    check("ferr_pkt", pkt, 1);
    check("ferr_sticky", perr, 1);

    // Reset mid-packet with the consumer stalled
    cready = 1'b0;
    pulse_clear();
    send(2'b01, 64'h10);
    send(2'b00, 64'h11);
    check("mid_valid", cvalid, 1);
    reset_poweron = 1'b1;
    @(negedge clk);
    reset_poweron = 1'b0;
    check("mid_rst_valid", cvalid, 0);
    check("mid_rst_ready", sready, 0);
    check("mid_rst_err", perr, 0);
    @(negedge clk);
    check("mid_ready_back", sready, 1);
    cready = 1'b1;
    send(2'b11, 64'h55);
    check("mid_after_data", cdata, 64'h55);
    check("mid_after_pkt", pkt, 1);
    check("mid_after_err", perr, 0);

    // Randomized traffic with stall phases and occasional clears
    for (int c = 0; c < 3000; c++) begin
      mvalid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: mcntl = 2'b00;
        4, 5:       mcntl = 2'b01;
        6, 7:       mcntl = 2'b10;
        default:    mcntl = 2'b11;
      endcase
      mdata  = {$urandom, $urandom};
      moob   = $urandom;
      mtype  = TYPE_W'($urandom);
      cready = ((c % 400) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clear  = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    mvalid = 1'b0;
    clear  = 1'b0;
    cready = 1'b1;
    repeat (12) @(negedge clk);

    // Saturation: bring the counter to 0xFFFE with back-to-back single-beat packets
    pulse_clear();
    mvalid = 1'b1;
    mcntl  = 2'b11;
    n = 0;
    g = 0;
    while (n < 65534 && g < 70000) begin
      mdata = DATA_W'(n);
      if (sready) n++;
      g++;
      @(negedge clk);
    end
    mvalid = 1'b0;
    check("sat_beats", n, 65534);
    check("sat_preload", pkt, 16'hFFFE);
    send(2'b11, 64'h1);
    check("sat_reach", pkt, 16'hFFFF);
    send(2'b11, 64'h2);
    send(2'b11, 64'h3);
    check("sat_hold", pkt, 16'hFFFF);
    send(2'b01, 64'h4);
    clear = 1'b1;
    send(2'b10, 64'h5);
    clear = 1'b0;
    check("clear_wins_cnt", pkt, 0);
    check("clear_wins_err", perr, 0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_up_rx.md
STACK_UP_RX -- requirements
Module: stack_up_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the upstream data field.
REQ-002 SHALL have parameter OOB_W, default 32, width of the out-of-band data field.
REQ-003 SHALL have parameter TYPE_W, default 2, width of the type field.
REQ-004 SHALL have parameter DEPTH, default 8, receive FIFO entries, power of 2, at least 4.
REQ-005 Ports SHALL be:
- clk  in  1  clock; one clock; all logic on the rising edge.
- reset_poweron  in  1  reset; synchronous, active-high.
- mgr__stu__valid  in  1  beat valid from manager.
- mgr__stu__cntl  in  2  framing: 01 SOM, 00 MOM, 10 EOM, 11 SOM_EOM.
- stu__mgr__ready  out  1  receiver can accept a beat.
- mgr__stu__type  in  TYPE_W  control/data, vector/scalar.
- mgr__stu__data  in  DATA_W  payload.
- mgr__stu__oob_data  in  OOB_W  out-of-band payload.
- stu__cons__valid  out  1  beat valid toward consumer.
- stu__cons__cntl  out  2  forwarded framing.
- stu__cons__type  out  TYPE_W  forwarded type.
- stu__cons__data  out  DATA_W  forwarded payload.
- stu__cons__oob_data  out  OOB_W  forwarded out-of-band payload.
- cons__stu__ready  in  1  consumer accepts the beat.
- sys__stu__clear  in  1  clears the counter and the sticky error.
- stu__sys__pktCount  out  16  packets accepted, saturating.
- stu__sys__protoErr  out  1  sticky framing-error flag.

Function
REQ-006 An input transfer SHALL occur in a cycle when mgr__stu__valid and stu__mgr__ready are both 1.
REQ-007 stu__mgr__ready SHALL be a flop, loaded each cycle with (next FIFO occupancy <= DEPTH-2).
- This absorbs one in-flight beat after deassertion; the FIFO never overflows.
REQ-008 The FIFO SHALL store {cntl, type, data, oob_data} per entry, first in first out.
- Pointers are log2(DEPTH) bits plus a wrap bit.
- Occupancy is 0..DEPTH.
REQ-009 An output transfer SHALL occur when stu__cons__valid and cons__stu__ready are both 1.
- stu__cons__valid = FIFO not empty.
- stu__cons__* shows the head entry, held stable until it is accepted.
REQ-010 Simultaneous write and read SHALL leave occupancy unchanged.
- When the FIFO is empty, a written beat appears on the output no earlier than the next cycle; latency in to out is 1 cycle minimum.
REQ-011 The framing FSM SHALL have states IDLE and IN_PKT, evaluated on accepted input beats only.
REQ-012 FSM transitions SHALL be:
- IDLE + SOM -> IN_PKT.
- IDLE + SOM_EOM -> IDLE, packet counted.
- IN_PKT + MOM -> IN_PKT.
- IN_PKT + EOM -> IDLE, packet counted.
REQ-013 Framing errors SHALL set stu__sys__protoErr.
- IDLE + MOM or EOM: the beat is dropped and not written to the FIFO; state stays IDLE.
- IN_PKT + SOM or SOM_EOM: the beat is written; the FSM restarts as if from IDLE; the aborted packet is not counted.
REQ-014 stu__sys__pktCount SHALL increment by 1 per completed packet and saturate at 16'hFFFF.
REQ-015 sys__stu__clear SHALL zero pktCount and protoErr next cycle.
- Clear wins over a simultaneous increment or error.
- Clear does not affect the FIFO or the FSM.
REQ-016 A write attempted while the FIFO is full SHALL be impossible by construction.
- A verification assertion flags it.

Reset
REQ-017 While reset_poweron = 1 at a clock edge, the block SHALL go to this state next cycle:
- FIFO empty, pointers 0.
- FSM in IDLE.
- stu__mgr__ready = 0.
- stu__cons__valid = 0, stu__cons__cntl/type/data/oob_data = 0.
- pktCount = 0, protoErr = 0.
REQ-018 stu__mgr__ready SHALL assert 1 cycle after reset deasserts.
REQ-019 Reset mid-packet SHALL discard all buffered beats and the partial packet, with no error flagged.

Verification
REQ-020 Single beat: SOM_EOM, data 0x1234, consumer ready -> output 1 cycle later; pktCount = 1; protoErr = 0.
REQ-021 Backpressure: cons ready = 0, 10 back-to-back beats offered:
- ready drops after the occupancy reaches DEPTH-1 (7);
- no beat lost or duplicated;
- all drain in order once cons ready = 1.
REQ-022 Framing error: MOM in IDLE -> beat dropped, protoErr = 1; then SOM,MOM,EOM -> 3 beats forwarded, pktCount = 1.
REQ-023 Saturation/clear: preload pktCount to 0xFFFE, send 3 packets -> 0xFFFF; clear together with an EOM -> 0 next cycle.
REQ-024 Reset after SOM,MOM with the consumer stalled -> FIFO empty, valid = 0, FSM IDLE; a following SOM_EOM is counted normally.
